// File: rtl/max_unpooling_4_8.sv
// max_unpooling_4_8: rebuilds an 8x8 map of 9-bit elements from a 4x4 map of
// 4-bit pooled values. Index mode places each value at its argmax position and
// zeroes the rest of its window. Fill mode replicates each value over its window.
// One pooled row (two output rows) is written per cycle, so a conversion takes
// four cycles after the start edge.
module max_unpooling_4_8 (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_flag,
    input  logic [63:0]  val_in,
    input  logic [31:0]  idx_in,
    input  logic         fill_mode,
    output logic [575:0] out,
    output logic         busy,
    output logic         end_flag
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     row_q, row_d;
    logic [63:0]    val_q, val_d;
    logic [31:0]    idx_q, idx_d;
    logic           fill_q, fill_d;
    logic [575:0]   out_q, out_d;
    logic           busy_q, busy_d;
    logic           end_q, end_d;

    logic [3:0]     win_val;
    logic [1:0]     win_idx;
    logic [8:0]     v9;
    int             top_base;
    int             bot_base;

    // Next-state logic: latch inputs on start, then write two output rows per cycle
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        val_d    = val_q;
        idx_d    = idx_q;
        fill_d   = fill_q;
        out_d    = out_q;
        busy_d   = busy_q;
        end_d    = 1'b0;
        win_val  = 4'd0;
        win_idx  = 2'd0;
        v9       = 9'd0;
        top_base = 0;
        bot_base = 0;

        case (state_q)
            IDLE: begin
                if (start_flag) begin
                    val_d   = val_in;
                    idx_d   = idx_in;
                    fill_d  = fill_mode;
                    row_d   = 2'd0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int j = 0; j < 4; j++) begin
                    win_val  = val_q[63 - 4 * (4 * int'(row_q) + j) -: 4];
                    win_idx  = idx_q[31 - 2 * (4 * int'(row_q) + j) -: 2];
                    v9       = {5'b0, win_val};
                    // Upper output row is 2i, lower is 2i+1 (one full row = 72 bits below)
                    top_base = 575 - 9 * (16 * int'(row_q) + 2 * j);
                    bot_base = top_base - 72;
                    out_d[top_base -: 9]     = (fill_q || win_idx == 2'd0) ? v9 : 9'd0;
                    out_d[top_base - 9 -: 9] = (fill_q || win_idx == 2'd1) ? v9 : 9'd0;
                    out_d[bot_base -: 9]     = (fill_q || win_idx == 2'd2) ? v9 : 9'd0;
                    out_d[bot_base - 9 -: 9] = (fill_q || win_idx == 2'd3) ? v9 : 9'd0;
                end
                if (row_q == 2'd3) begin
                    end_d   = 1'b1;
                    busy_d  = 1'b0;
                    row_d   = 2'd0;
                    state_d = IDLE;
                end else begin
                    row_d = 2'(row_q + 2'd1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            row_q   <= 2'd0;
            val_q   <= 64'd0;
            idx_q   <= 32'd0;
            fill_q  <= 1'b0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            end_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            val_q   <= val_d;
            idx_q   <= idx_d;
            fill_q  <= fill_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            end_q   <= end_d;
        end
    end

    assign out      = out_q;
    assign busy     = busy_q;
    assign end_flag = end_q;

endmodule

// File: tb/tb_max_unpooling_4_8.sv
// Testbench for max_unpooling_4_8: a behavioural model built from the element
// placement rules and the four-cycle latency, checked every cycle, plus
// directed scenarios with hand-computed values.
module tb_max_unpooling_4_8;

    logic         clk;
    logic         reset;
    logic         start_flag;
    logic [63:0]  val_in;
    logic [31:0]  idx_in;
    logic         fill_mode;
    logic [575:0] out;
    logic         busy;
    logic         end_flag;

    int compared;
    int mismatched;

    max_unpooling_4_8 dut (
        .clk        (clk),
        .reset      (reset),
        .start_flag (start_flag),
        .val_in     (val_in),
        .idx_in     (idx_in),
        .fill_mode  (fill_mode),
        .out        (out),
        .busy       (busy),
        .end_flag   (end_flag)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Global time limit so the bench can never hang
    initial begin
        #200000;
        $display("[TB] FAIL timeout actual=running required=finished");
        $fatal(1, "[TB] time limit reached");
    end

    function automatic logic [8:0] elem(input logic [575:0] m, input int r, input int c);
        return m[575 - 9 * (8 * r + c) -: 9];
    endfunction

    // Element-wise definition of the result: each output element looks up its window
    function automatic logic [575:0] unpool(input logic [63:0] v, input logic [31:0] ix, input logic f);
        logic [575:0] m;
        logic [3:0]   pv;
        logic [1:0]   pi;
        int           i, j, pos;
        m = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                i   = r / 2;
                j   = c / 2;
                pv  = v[63 - 4 * (4 * i + j) -: 4];
                pi  = ix[31 - 2 * (4 * i + j) -: 2];
                pos = (r % 2) * 2 + (c % 2);
                if (f || int'(pi) == pos)
                    m[575 - 9 * (8 * r + c) -: 9] = {5'b0, pv};
            end
        end
        return m;
    endfunction

    function automatic int count_equal(input logic [575:0] m, input logic [8:0] x);
        int n;
        n = 0;
        for (int k = 0; k < 64; k++)
            if (m[575 - 9 * k -: 9] == x) n++;
        return n;
    endfunction

    task automatic check_output(input string name, input logic [575:0] actual, input logic [575:0] required);
        compared++;
        if (actual !== required) begin
            mismatched++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
        end
    endtask

    // Reference model: tracks the conversion timeline cycle by cycle
    int           remaining;
    logic         model_valid;
    logic         exp_busy;
    logic         exp_end;
    logic [575:0] exp_out;
    logic [63:0]  lat_val;
    logic [31:0]  lat_idx;
    logic         lat_fill;

    initial begin
        remaining   = 0;
        model_valid = 1'b0;
        exp_busy    = 1'b0;
        exp_end     = 1'b0;
        exp_out     = '0;
    end

    always @(posedge clk) begin
        exp_end = 1'b0;
        if (reset) begin
            remaining   = 0;
            exp_busy    = 1'b0;
            exp_out     = '0;
            model_valid = 1'b1;
        end else if (remaining == 0) begin
            if (start_flag) begin
                lat_val   = val_in;
                lat_idx   = idx_in;
                lat_fill  = fill_mode;
                remaining = 4;
                exp_busy  = 1'b1;
            end
        end else begin
            remaining--;
            if (remaining == 0) begin
                exp_out  = unpool(lat_val, lat_idx, lat_fill);
                exp_end  = 1'b1;
                exp_busy = 1'b0;
            end
        end
    end

    // Per-cycle compare of the DUT against the model, away from the active edge
    always @(negedge clk) begin
        if (model_valid) begin
            check_output("cyc_busy", {575'd0, busy}, {575'd0, exp_busy});
            check_output("cyc_end_flag", {575'd0, end_flag}, {575'd0, exp_end});
            if (!exp_busy)
                check_output("cyc_out", out, exp_out);
        end
    end

    // Drive one start pulse and measure cycles from the start edge to end_flag
    task automatic apply_stimulus(input logic [63:0] v, input logic [31:0] ix, input logic f,
                                  output int latency);
        @(negedge clk);
        val_in     = v;
        idx_in     = ix;
        fill_mode  = f;
        start_flag = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_flag = 1'b0;
        latency    = -1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (end_flag) begin
                latency = n;
                break;
            end
        end
    endtask

    int           lat;
    int           ends_seen;
    int           busy_low;
    int           bad;
    logic [575:0] ref_a;

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        start_flag = 1'b1;
        val_in     = 64'hFFFF_FFFF_FFFF_FFFF;
        idx_in     = 32'd0;
        fill_mode  = 1'b1;

        // Reset held two cycles with a start request that must be ignored
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset      = 1'b0;
        start_flag = 1'b0;
        check_output("reset_out", out, '0);
        check_output("reset_busy", {575'd0, busy}, 576'd0);
        check_output("reset_end", {575'd0, end_flag}, 576'd0);
        repeat (2) @(negedge clk);
        check_output("reset_start_ignored", {575'd0, busy}, 576'd0);

        // Hand literals pin the model's placement rules
        ref_a = unpool(64'hFFFF_FFFF_FFFF_FFFF, 32'h0055_AAFF, 1'b0);
        check_output("model_pin_00", {567'd0, elem(ref_a, 0, 0)}, {567'd0, 9'h00F});
        check_output("model_pin_21", {567'd0, elem(ref_a, 2, 1)}, {567'd0, 9'h00F});
        check_output("model_pin_77", {567'd0, elem(ref_a, 7, 7)}, {567'd0, 9'h00F});
        ref_a = unpool(64'h0123_4567_89AB_CDEF, 32'd0, 1'b1);
        check_output("model_pin_fill34", {567'd0, elem(ref_a, 3, 4)}, {567'd0, 9'd6});

        // Index mode corners: idx 0/1/2/3 per pooled row
        apply_stimulus(64'hFFFF_FFFF_FFFF_FFFF, 32'h0055_AAFF, 1'b0, lat);
        check_output("idx_latency", 576'(lat), 576'd4);
        check_output("idx_out00", {567'd0, elem(out, 0, 0)}, {567'd0, 9'h00F});
        check_output("idx_out10", {567'd0, elem(out, 1, 0)}, 576'd0);
        check_output("idx_out21", {567'd0, elem(out, 2, 1)}, {567'd0, 9'h00F});
        check_output("idx_out20", {567'd0, elem(out, 2, 0)}, 576'd0);
        check_output("idx_out50", {567'd0, elem(out, 5, 0)}, {567'd0, 9'h00F});
        check_output("idx_out77", {567'd0, elem(out, 7, 7)}, {567'd0, 9'h00F});
        check_output("idx_nonzero", 576'(64 - count_equal(out, 9'd0)), 576'd16);

        // Fill mode: element (r,c) = 4*(r>>1) + (c>>1)
        apply_stimulus(64'h0123_4567_89AB_CDEF, 32'h1234_5678, 1'b1, lat);
        check_output("fill_latency", 576'(lat), 576'd4);
        check_output("fill_out77", {567'd0, elem(out, 7, 7)}, {567'd0, 9'd15});
        check_output("fill_out34", {567'd0, elem(out, 3, 4)}, {567'd0, 9'd6});
        bad = 0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                if (elem(out, r, c) != 9'(4 * (r >> 1) + (c >> 1))) bad++;
        check_output("fill_all_elems_bad", 576'(bad), 576'd0);

        // Stale-data overwrite: full fill then sparse index result
        apply_stimulus(64'hFFFF_FFFF_FFFF_FFFF, 32'd0, 1'b1, lat);
        check_output("stale_fill_ones", 576'(count_equal(out, 9'h00F)), 576'd64);
        apply_stimulus(64'h1111_1111_1111_1111, 32'd0, 1'b0, lat);
        check_output("stale_count_one", 576'(count_equal(out, 9'd1)), 576'd16);
        check_output("stale_count_zero", 576'(count_equal(out, 9'd0)), 576'd48);

        // Start while busy: second pulse at E2 must be ignored
        ref_a = unpool(64'h0123_4567_89AB_CDEF, 32'h1B1B_E4E4, 1'b0);
        busy_low  = 0;
        ends_seen = 0;
        @(negedge clk);
        val_in     = 64'h0123_4567_89AB_CDEF;
        idx_in     = 32'h1B1B_E4E4;
        fill_mode  = 1'b0;
        start_flag = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_flag = 1'b0;
        if (!busy) busy_low++;
        @(negedge clk);
        if (!busy) busy_low++;
        val_in     = 64'hAAAA_5555_AAAA_5555;
        idx_in     = 32'hFFFF_0000;
        fill_mode  = 1'b1;
        start_flag = 1'b1;
        @(negedge clk);
        start_flag = 1'b0;
        if (!busy) busy_low++;
        @(negedge clk);
        if (!busy) busy_low++;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (end_flag) ends_seen++;
        end
        check_output("busy_start_busy_low", 576'(busy_low), 576'd0);
        check_output("busy_start_ends", 576'(ends_seen), 576'd1);
        check_output("busy_start_result", out, ref_a);

        // Reset at E2 aborts the run; a fresh run must then complete normally
        @(negedge clk);
        val_in     = 64'hFEDC_BA98_7654_3210;
        idx_in     = 32'hE4E4_E4E4;
        fill_mode  = 1'b0;
        start_flag = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_flag = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_output("abort_out", out, '0);
        check_output("abort_busy", {575'd0, busy}, 576'd0);
        ends_seen = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (end_flag) ends_seen++;
        end
        check_output("abort_no_end", 576'(ends_seen), 576'd0);
        apply_stimulus(64'h8421_0F0F_7E7E_1357, 32'h39C6_A55A, 1'b0, lat);
        check_output("rerun_latency", 576'(lat), 576'd4);
        check_output("rerun_out", out, unpool(64'h8421_0F0F_7E7E_1357, 32'h39C6_A55A, 1'b0));

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
